alu_pipe: RTL and testbench

Parametrised, pipelined WIDTH-bit ALU that supersedes per-bit slice arrays in the datapath. It implements the same 8-function table (add, add-with-inverted-B, NOT A, NOT B, OR, OR-NOT, AND, AND-NOT) across a full word. It adds registered operands and results, valid/ready flow control on both sides, and status flags. It sits between the register-file read stage and writeback in the 3-stage processor pipe.

---
 rtl/alu_pipe_pkg.sv | 23 ++
 rtl/alu_word_comb.sv | 64 ++++++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared op-codes, flag bit positions and op-class helper for the pipelined ALU.
// Used by alu_pipe and alu_word_comb.
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADDNB = 3'b001;
    localparam logic [2:0] OP_NOTA  = 3'b010;
    localparam logic [2:0] OP_NOTB  = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_ORNB  = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_ANDNB = 3'b111;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    function automatic logic is_arith(input logic [2:0] op);
        return (op[2:1] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_word_comb.sv
// Combinational WIDTH-bit ALU evaluation: result and {V,N,Z,C} from op, a, b and carry-in.
// Carries no state; alu_pipe registers both its inputs and its outputs.
module alu_word_comb
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] low_sum_s;
    logic             msb_cin_s;
    logic             msb_cout_s;

    // Op bit 0 selects inverted B for both the adder and the OR/AND variants
    always_comb begin
        b_eff_s = b;
        if (op[0]) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
    end

    // Full-word sum plus a sum of the low bits only, whose top bit is the carry into the MSB
    always_comb begin
        sum_s      = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin};
        low_sum_s  = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff_s[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, cin};
        msb_cin_s  = low_sum_s[WIDTH-1];
        msb_cout_s = sum_s[WIDTH];
    end

    // Function table and flag generation
    always_comb begin
        result = {WIDTH{1'b0}};
        flags  = 4'b0000;
        case (op)
            OP_ADD, OP_ADDNB: result = sum_s[WIDTH-1:0];
            OP_NOTA:          result = ~a;
            OP_NOTB:          result = ~b;
            OP_OR, OP_ORNB:   result = a | b_eff_s;
            OP_AND, OP_ANDNB: result = a & b_eff_s;
            default:          result = {WIDTH{1'b0}};
        endcase
        if (is_arith(op)) begin
            flags[FLAG_C] = msb_cout_s;
            flags[FLAG_V] = msb_cin_s ^ msb_cout_s;
        end else begin
            flags[FLAG_C] = 1'b0;
            flags[FLAG_V] = 1'b0;
        end
        flags[FLAG_Z] = (result == {WIDTH{1'b0}});
        flags[FLAG_N] = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU with valid/ready on both sides and {V,N,Z,C} flags.
// Define ALU_PIPE_CARRY_CHAIN_EN to add a stored carry selectable through in_cin_sel.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_cin_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    logic             s1_valid_r;
    logic [2:0]       s1_op_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             s1_cin_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_result_r;
    logic [3:0]       out_flags_r;

    logic             s2_can_accept_s;
    logic             in_fire_s;
    logic             s1_xfer_s;
    logic             cin_eff_s;
    logic [WIDTH-1:0] word_result_s;
    logic [3:0]       word_flags_s;

    // Handshake: S1 frees up in the same cycle it hands over to S2, so flow has no bubble
    always_comb begin
        s2_can_accept_s = !out_valid_r || out_ready;
        in_ready        = !s1_valid_r || s2_can_accept_s;
        in_fire_s       = in_valid && in_ready;
        s1_xfer_s       = s1_valid_r && s2_can_accept_s;
    end

`ifdef ALU_PIPE_CARRY_CHAIN_EN
    logic s1_cin_sel_r;
    logic carry_r;

    // Carry-source select registered alongside the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_cin_sel_r <= 1'b0;
        end else if (in_fire_s) begin
            s1_cin_sel_r <= in_cin_sel;
        end else begin
            s1_cin_sel_r <= s1_cin_sel_r;
        end
    end

    // Stored carry tracks the last arithmetic op entering S2, so a chained op right behind sees it
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else if (s1_xfer_s && is_arith(s1_op_r)) begin
            carry_r <= word_flags_s[FLAG_C];
        end else begin
            carry_r <= carry_r;
        end
    end

    // Effective carry-in: stored carry when the op asked for it
    always_comb begin
        cin_eff_s = s1_cin_r;
        if (s1_cin_sel_r) begin
            cin_eff_s = carry_r;
        end else begin
            cin_eff_s = s1_cin_r;
        end
    end
`else
    logic unused_cin_sel_s;

    // Without chaining the select pin is kept only for pin compatibility
    always_comb begin
        unused_cin_sel_s = in_cin_sel;
        cin_eff_s        = s1_cin_r;
    end
`endif

    // S1 operand register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'b000;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_cin_r   <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= in_op;
            s1_a_r     <= in_a;
            s1_b_r     <= in_b;
            s1_cin_r   <= in_cin;
        end else if (s1_xfer_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    alu_word_comb #(
        .WIDTH (WIDTH)
    ) u_word (
        .op     (s1_op_r),
        .a      (s1_a_r),
        .b      (s1_b_r),
        .cin    (cin_eff_s),
        .result (word_result_s),
        .flags  (word_flags_s)
    );

    // S2 result register; contents hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_flags_r  <= 4'b0000;
        end else if (s1_xfer_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= word_result_s;
            out_flags_r  <= word_flags_s;
        end else if (out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_flags  = out_flags_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8) with a result scoreboard and an independent model.
// Follows ALU_PIPE_CARRY_CHAIN_EN when the bench is compiled with it.
module tb_alu_pipe;

`ifdef ALU_PIPE_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'b000;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_cin = 1'b0;
    logic       in_cin_sel = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_result;
    logic [3:0] out_flags;

    int total = 0;
    int bad = 0;
    int pops = 0;
    logic       acc;
    logic       mcarry = 1'b0;
    logic [7:0] last_res;
    logic [3:0] last_flags;
    logic [7:0] held;
    logic [11:0] sb[$];

    alu_pipe #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_cin_sel (in_cin_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: returns {V,N,Z,C,result}
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic [7:0] bx;
        logic [7:0] r;
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        bx = op[0] ? ~b : b;
        case (op)
            3'd0, 3'd1: begin
                s = {1'b0, a} + {1'b0, bx} + {8'd0, cin};
                r = s[7:0];
                c = s[8];
                v = (a[7] == bx[7]) && (r[7] != a[7]);
            end
            3'd2: r = ~a;
            3'd3: r = ~b;
            3'd4: r = a | b;
            3'd5: r = a | ~b;
            3'd6: r = a & b;
            default: r = a & ~b;
        endcase
        return {v, r[7], (r == 8'h00), c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic sel);
        in_valid = v;
        in_op = op;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_cin_sel = sel;
    endtask

    // One clock: settle-point handshake bookkeeping, then the edge
    task automatic tick();
        logic [11:0] e;
        logic c_eff;
        @(negedge clk);
        acc = 1'b0;
        if (rst) begin
            sb.delete();
            mcarry = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                total++;
                assert (sb.size() > 0) else begin
                    bad++;
                    $error("FAIL sb_underflow: observed=%0h expected=empty-free", out_result);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_result", {24'd0, out_result}, {24'd0, e[7:0]});
                    chk("sb_flags", {28'd0, out_flags}, {28'd0, e[11:8]});
                    last_res = out_result;
                    last_flags = out_flags;
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                c_eff = (CHAIN && in_cin_sel) ? mcarry : in_cin;
                e = model(in_op, in_a, in_b, c_eff);
                if (CHAIN && in_op[2:1] == 2'b00) mcarry = e[8];
                sb.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && (sb.size() > 0 || out_valid); i++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_in_ready", in_ready, 1);

        // Signed overflow on add, with two-edge latency
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 8'h7F, 8'h01, 1'b0, 1'b0);
        tick();
        chk("add_accept", acc, 1);
        in_valid = 1'b0;
        chk("lat_edge1_valid", out_valid, 0);
        tick();
        chk("lat_edge2_valid", out_valid, 1);
        chk("add_result", out_result, 8'h80);
        chk("add_flags", out_flags, 4'b1100);
        tick();

        // Subtract to zero
        drive(1'b1, 3'b001, 8'h05, 8'h05, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("sub_result", out_result, 8'h00);
        chk("sub_flags", out_flags, 4'b0011);
        tick();

        // Back-to-back logic ops at full rate
        drive(1'b1, 3'b110, 8'hF0, 8'h3C, 1'b0, 1'b0);
        chk("b2b_ready0", in_ready, 1);
        tick();
        drive(1'b1, 3'b101, 8'hF0, 8'h3C, 1'b0, 1'b0);
        chk("b2b_ready1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_res0", out_result, 8'h30);
        tick();
        chk("b2b_valid1", out_valid, 1);
        chk("b2b_res1", out_result, 8'hF3);
        chk("b2b_flags1", out_flags, 4'b0100);
        drain();

        // Backpressure with three offered ops
        pops = 0;
        out_ready = 1'b0;
        begin
            logic [2:0] ops [3];
            logic [7:0] as [3];
            logic [7:0] bs [3];
            int idx;
            ops[0] = 3'b000; as[0] = 8'h10; bs[0] = 8'h20;
            ops[1] = 3'b100; as[1] = 8'h0F; bs[1] = 8'hF0;
            ops[2] = 3'b010; as[2] = 8'h55; bs[2] = 8'h00;
            idx = 0;
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, ops[idx], as[idx], bs[idx], 1'b0, 1'b0);
                if (c >= 2) chk("bp_in_ready", in_ready, 0);
                if (c == 2) held = out_result;
                if (c == 3) begin
                    chk("bp_hold_result", out_result, held);
                    chk("bp_hold_valid", out_valid, 1);
                end
                tick();
                if (acc) idx++;
            end
            chk("bp_accepts", idx, 2);
            out_ready = 1'b1;
            for (int t = 0; t < 10 && idx < 3; t++) begin
                drive(1'b1, ops[idx], as[idx], bs[idx], 1'b0, 1'b0);
                tick();
                if (acc) idx++;
            end
            chk("bp_third_accept", idx, 3);
        end
        drain();
        chk("bp_pop_count", pops, 3);
        chk("bp_last_result", last_res, 8'hAA);

        // Two-word add: low word then high word using the stored carry
        drive(1'b1, 3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b000, 8'h01, 8'h00, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("chain_low_res", last_res, 8'h00);
        chk("chain_low_flags", last_flags, 4'b0011);
        tick();
        chk("chain_high_res", last_res, CHAIN ? 8'h02 : 8'h01);

        // Reset with both stages occupied
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b110, 8'h0F, 8'h0F, 1'b0, 1'b0);
        tick();
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_result", out_result, 0);
        chk("mid_rst_out_flags", out_flags, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        pops = 0;
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 8'h10, 8'h20, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("post_rst_pops", pops, 1);
        chk("post_rst_carry_res", last_res, CHAIN ? 8'h30 : 8'h31);

        // Mixed ops under random consumer stalls
        for (int n = 0; n < 24; n++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            chk("mix_accept", acc, 1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
